// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver with configurable data width, parity and stop
// bits. It has a 2-flop input synchroniser, start-bit glitch rejection,
// parity and framing error flags, and a valid/ready output register.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        synchronous, active-high reset
//   rx_i           asynchronous serial line, idle high
//   enable_i       low = no new frame is started
//   data_o         received word, LSB first on the line
//   data_valid_o   output register holds a frame
//   data_ready_i   consumer takes the frame when high with data_valid_o
//   parity_err_o   parity mismatch for the frame on data_o
//   frame_err_o    a stop bit was sampled low for the frame on data_o
//   overrun_o      1-cycle pulse when a finished frame is dropped
//   busy_o         receiver is not idle
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | re-checking the start bit at its centre
// DATA  | sampling data bits, one per bit period
// PAR   | sampling the parity bit
// STOP  | sampling the stop bit(s)
module uart_rx_frame #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BIT_RATE  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rx_i,
  input  logic                 enable_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);
  localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF      = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state_q, state_d;
  logic                 sync_q, rx_s_q, rx_prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  // Error flags of the frame currently on the line.
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 commit_q, commit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, pout_q, pout_d, fout_q, fout_d;
  logic                 ovr_q, ovr_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= rx_i;
      rx_s_q    <= sync_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    commit_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Needs a high-to-low transition, so a held-low line never retriggers.
        if (enable_i && !rx_s_q && rx_prev_q) begin
          state_d = START;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end
        end
      end
      PAR: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          perr_d  = (PARITY == 1) ? ~(^shift_q ^ rx_s_q) : (^shift_q ^ rx_s_q);
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          bit_d = bit_q + 1'b1;
          if (!rx_s_q) ferr_d = 1'b1;
          if (bit_q == STOP_LAST) begin
            state_d  = IDLE;
            commit_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = valid_q;
    data_d  = data_q;
    pout_d  = pout_q;
    fout_d  = fout_q;
    ovr_d   = 1'b0;
    if (valid_q && data_ready_i) valid_d = 1'b0;
    // A handshake in the commit cycle frees the register for the new frame.
    if (commit_q) begin
      if (!valid_q || data_ready_i) begin
        valid_d = 1'b1;
        data_d  = shift_q;
        pout_d  = perr_q;
        fout_d  = ferr_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      commit_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      pout_q   <= 1'b0;
      fout_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      commit_q <= commit_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      pout_q   <= pout_d;
      fout_q   <= fout_d;
      ovr_q    <= ovr_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign parity_err_o = pout_q;
  assign frame_err_o  = fout_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: four receivers (8N1, 8E1, 8O1, 7N2) at 10 clocks
// per bit, each with its own line and ready input. Expected frames come from
// a line-level model of the frame format.
module tb_uart_rx_frame;
  localparam int CPB = 10;

  logic clk_i;
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       reset_i, enable_i;
  logic [3:0] rx_l, rdy_l;
  wire  [7:0] d0, d1, d2;
  wire  [6:0] d3;
  wire  [3:0] vld, perr, ferr, ovr, busy;
  wire  [8:0] dat [4];
  assign dat[0] = {1'b0, d0};
  assign dat[1] = {1'b0, d1};
  assign dat[2] = {1'b0, d2};
  assign dat[3] = {2'b00, d3};

  uart_rx_frame #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk_i(clk_i), .reset_i(reset_i), .rx_i(rx_l[0]), .enable_i(enable_i), .data_o(d0),
    .data_valid_o(vld[0]), .data_ready_i(rdy_l[0]), .parity_err_o(perr[0]),
    .frame_err_o(ferr[0]), .overrun_o(ovr[0]), .busy_o(busy[0]));
  uart_rx_frame #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk_i(clk_i), .reset_i(reset_i), .rx_i(rx_l[1]), .enable_i(enable_i), .data_o(d1),
    .data_valid_o(vld[1]), .data_ready_i(rdy_l[1]), .parity_err_o(perr[1]),
    .frame_err_o(ferr[1]), .overrun_o(ovr[1]), .busy_o(busy[1]));
  uart_rx_frame #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk_i(clk_i), .reset_i(reset_i), .rx_i(rx_l[2]), .enable_i(enable_i), .data_o(d2),
    .data_valid_o(vld[2]), .data_ready_i(rdy_l[2]), .parity_err_o(perr[2]),
    .frame_err_o(ferr[2]), .overrun_o(ovr[2]), .busy_o(busy[2]));
  uart_rx_frame #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk_i(clk_i), .reset_i(reset_i), .rx_i(rx_l[3]), .enable_i(enable_i), .data_o(d3),
    .data_valid_o(vld[3]), .data_ready_i(rdy_l[3]), .parity_err_o(perr[3]),
    .frame_err_o(ferr[3]), .overrun_o(ovr[3]), .busy_o(busy[3]));

  typedef struct {
    int         u;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    int         cyc;
  } rec_t;

  rec_t got_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   fall_cyc [4];
  int   ovr_cnt [4];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Every accepted handshake and every overrun pulse, sampled mid-cycle.
  initial begin
    for (int i = 0; i < 4; i++) ovr_cnt[i] = 0;
    forever begin
      @(negedge clk_i);
      #3;
      for (int u = 0; u < 4; u++) begin
        if (vld[u] && rdy_l[u]) got_q.push_back('{u, dat[u], perr[u], ferr[u], cyc});
        if (ovr[u]) ovr_cnt[u] = ovr_cnt[u] + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic int db(input int u);
    return (u == 3) ? 7 : 8;
  endfunction
  function automatic int pm(input int u);
    case (u)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction
  function automatic int sbn(input int u);
    return (u == 3) ? 2 : 1;
  endfunction
  function automatic logic [8:0] dmask(input int u, input logic [8:0] d);
    return d & 9'((1 << db(u)) - 1);
  endfunction
  // Parity bit value that makes the frame's parity correct.
  function automatic logic good_par(input int u, input logic [8:0] d);
    logic ones;
    ones = ^dmask(u, d);
    return (pm(u) == 2) ? ones : ~ones;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_frame(input int u, input logic [8:0] d, input logic pb, input logic [1:0] sb);
    logic [11:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < db(u); i++) begin
      bits[n] = d[i];
      n++;
    end
    if (pm(u) != 0) begin
      bits[n] = pb;
      n++;
    end
    for (int i = 0; i < sbn(u); i++) begin
      bits[n] = sb[i];
      n++;
    end
    fall_cyc[u] = cyc;
    for (int i = 0; i < n; i++) begin
      rx_l[u] = bits[i];
      tick(CPB);
    end
  endtask

  task automatic expect_frame(input string tag, input int u, input logic [8:0] d,
                              input logic pb, input logic [1:0] sb, input bit lat);
    rec_t r;
    int   w;
    logic pe_exp, fe_exp;
    int   lat_exp, lat_obs;
    w = 0;
    while (got_q.size() == 0 && w < 400) begin
      tick();
      w++;
    end
    chk({tag, "_arrived"}, 32'(got_q.size() != 0), 32'd1);
    if (got_q.size() == 0) return;
    r = got_q.pop_front();
    pe_exp = (pm(u) != 0) && (pb != good_par(u, d));
    fe_exp = (sb[0] == 1'b0) || (sbn(u) == 2 && sb[1] == 1'b0);
    chk({tag, "_unit"}, 32'(r.u), 32'(u));
    chk({tag, "_data"}, 32'(r.data), 32'(dmask(u, d)));
    chk({tag, "_parity_err"}, 32'(r.pe), 32'(pe_exp));
    chk({tag, "_frame_err"}, 32'(r.fe), 32'(fe_exp));
    if (lat) begin
      lat_exp = 2 + (1 + db(u) + ((pm(u) != 0) ? 1 : 0) + sbn(u)) * CPB - CPB / 2 + 2;
      lat_obs = r.cyc - fall_cyc[u];
      tests++;
      assert (lat_obs >= lat_exp - 3 && lat_obs <= lat_exp + 3) else begin
        fails++;
        $error("FAIL %s_latency observed=%0d expected=%0d+-3", tag, lat_obs, lat_exp);
      end
    end
  endtask

  task automatic pulse_ready_on_commit(input int u);
    int w;
    w = 0;
    while (!busy[u] && w < 100) begin
      tick();
      w++;
    end
    chk("watch_busy_rise", 32'(busy[u]), 32'd1);
    w = 0;
    while (busy[u] && w < 300) begin
      tick();
      w++;
    end
    chk("watch_busy_fall", 32'(busy[u]), 32'd0);
    // First idle cycle after the last stop sample is the commit cycle.
    rdy_l[u] = 1'b1;
    tick();
    rdy_l[u] = 1'b0;
  endtask

  initial begin
    logic [8:0] rd;
    logic       rpb;
    logic [1:0] rsb;
    int         ru;
    logic [8:0] v55;

    reset_i  = 1'b1;
    enable_i = 1'b1;
    rx_l     = 4'hF;
    rdy_l    = 4'hF;
    tick(3);
    reset_i = 1'b0;
    tick(2);

    chk("rst_data", 32'(dat[0]), 32'd0);
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_perr", 32'(perr), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // 8N1 basic frame
    send_frame(0, 9'h0A5, 1'b0, 2'b11);
    chk("t1_busy_after_stop", 32'(busy[0]), 32'd0);
    expect_frame("t1", 0, 9'h0A5, 1'b0, 2'b11, 1'b1);
    chk("t1_valid_one_cycle", 32'(vld[0]), 32'd0);

    // parity
    send_frame(1, 9'h03C, 1'b0, 2'b11);
    expect_frame("t2_even_ok", 1, 9'h03C, 1'b0, 2'b11, 1'b1);
    send_frame(1, 9'h03C, 1'b1, 2'b11);
    expect_frame("t2_even_bad", 1, 9'h03C, 1'b1, 2'b11, 1'b0);
    send_frame(2, 9'h001, 1'b0, 2'b11);
    expect_frame("t2_odd_ok", 2, 9'h001, 1'b0, 2'b11, 1'b1);
    tick(5);

    // start-bit glitch
    rx_l[0] = 1'b0;
    tick(3);
    rx_l[0] = 1'b1;
    chk("t3_glitch_busy", 32'(busy[0]), 32'd1);
    tick(8);
    chk("t3_glitch_idle", 32'(busy[0]), 32'd0);
    chk("t3_glitch_no_frame", 32'(got_q.size()), 32'd0);

    // framing error, then break
    send_frame(0, 9'h05A, 1'b0, 2'b00);
    expect_frame("t4_stop0", 0, 9'h05A, 1'b0, 2'b00, 1'b0);
    tick(30 * CPB);
    chk("t4_break_no_frame", 32'(got_q.size()), 32'd0);
    chk("t4_break_idle", 32'(busy[0]), 32'd0);
    rx_l[0] = 1'b1;
    tick(3 * CPB);
    send_frame(0, 9'h012, 1'b0, 2'b11);
    expect_frame("t4_after_break", 0, 9'h012, 1'b0, 2'b11, 1'b1);

    // enable low blocks new frames
    enable_i = 1'b0;
    send_frame(0, 9'h033, 1'b0, 2'b11);
    tick(2 * CPB);
    chk("en_off_no_frame", 32'(got_q.size()), 32'd0);
    chk("en_off_idle", 32'(busy[0]), 32'd0);
    enable_i = 1'b1;

    // overrun
    rdy_l[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b11);
    send_frame(0, 9'h022, 1'b0, 2'b11);
    tick(3);
    chk("t5_hold_valid", 32'(vld[0]), 32'd1);
    chk("t5_hold_data", 32'(dat[0]), 32'h11);
    chk("t5_overrun_once", 32'(ovr_cnt[0]), 32'd1);
    rdy_l[0] = 1'b1;
    tick();
    chk("t5_valid_drop", 32'(vld[0]), 32'd0);
    expect_frame("t5_drain", 0, 9'h011, 1'b0, 2'b11, 1'b0);
    rdy_l[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b11);
    fork
      send_frame(0, 9'h022, 1'b0, 2'b11);
      pulse_ready_on_commit(0);
    join
    tick(3);
    chk("t5b_new_data", 32'(dat[0]), 32'h22);
    chk("t5b_valid", 32'(vld[0]), 32'd1);
    chk("t5b_no_overrun", 32'(ovr_cnt[0]), 32'd1);
    expect_frame("t5b_old", 0, 9'h011, 1'b0, 2'b11, 1'b0);
    rdy_l[0] = 1'b1;
    tick();
    expect_frame("t5b_new", 0, 9'h022, 1'b0, 2'b11, 1'b0);

    // randomized frames against the model
    for (int k = 0; k < 24; k++) begin
      ru  = int'($urandom_range(0, 3));
      rd  = 9'($urandom);
      rpb = good_par(ru, rd) ^ ($urandom_range(0, 3) == 0);
      rsb = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      send_frame(ru, rd, rpb, rsb);
      expect_frame("rand", ru, rd, rpb, rsb, 1'b1);
      rx_l[ru] = 1'b1;
      tick(CPB);
    end

    // 7N2: reset mid-frame, then clean and stop-error frames
    rdy_l[3] = 1'b0;
    send_frame(3, 9'h02A, 1'b0, 2'b11);
    tick(3);
    chk("t6_pre_valid", 32'(vld[3]), 32'd1);
    chk("t6_pre_data", 32'(dat[3]), 32'h2A);
    v55 = 9'h055;
    rx_l[3] = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_l[3] = v55[i];
      tick(CPB);
    end
    rx_l[3] = v55[3];
    tick(CPB / 2);
    chk("t6_pre_busy", 32'(busy[3]), 32'd1);
    reset_i  = 1'b1;
    rx_l[3]  = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("t6_rst_data", 32'(dat[3]), 32'd0);
    chk("t6_rst_valid", 32'(vld[3]), 32'd0);
    chk("t6_rst_perr", 32'(perr[3]), 32'd0);
    chk("t6_rst_ferr", 32'(ferr[3]), 32'd0);
    chk("t6_rst_ovr", 32'(ovr[3]), 32'd0);
    chk("t6_rst_busy", 32'(busy[3]), 32'd0);
    tick(10 * CPB);
    chk("t6_post_rst_no_frame", 32'(got_q.size()), 32'd0);
    rdy_l[3] = 1'b1;
    send_frame(3, 9'h055, 1'b0, 2'b11);
    expect_frame("t6_clean", 3, 9'h055, 1'b0, 2'b11, 1'b1);
    send_frame(3, 9'h055, 1'b0, 2'b01);
    expect_frame("t6_stop2_bad", 3, 9'h055, 1'b0, 2'b01, 1'b1);
    rx_l[3] = 1'b1;
    tick(2 * CPB);
    chk("end_no_extra_frames", 32'(got_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
